// File: rtl/hart_fetch_pc.sv
// Per-hart program-counter file and registered fetch address for the IF stage.
// One PC per hart; the issued hart's PC goes to the output register and advances by 4.
// Start, kill, branch and i-cache-miss events retarget a hart's PC and take priority over issue.
module hart_fetch_pc #(
   parameter int unsigned         HART_NUM = 4,
   parameter int unsigned         PC_W     = 32,
   parameter logic [PC_W-1:0]     RESET_PC = '0,
   localparam int unsigned        HID_W    = (HART_NUM > 1) ? $clog2(HART_NUM) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [HID_W-1:0]    hart_issue_hid,
   input  logic [HART_NUM-1:0] hart_issue_hstate,
   input  logic                if_stall,
   input  logic                if_flush,
   input  logic                hstart,
   input  logic                hkill,
   input  logic [HID_W-1:0]    set_hart_id,
   input  logic [PC_W-1:0]     set_pc,
   input  logic                br_taken,
   input  logic [HID_W-1:0]    br_hart_id,
   input  logic [PC_W-1:0]     br_tgt,
   input  logic                ic_miss,
   input  logic [HID_W-1:0]    ic_miss_hart_id,
   input  logic [PC_W-1:0]     ic_miss_pc,
   output logic [PC_W-1:0]     if_pc,
   output logic [HID_W-1:0]    if_hart_id,
   output logic [HART_NUM-1:0] if_hstate,
   output logic                if_valid,
   output logic [HART_NUM-1:0] hart_live
);

   logic [PC_W-1:0]     pc_q [HART_NUM];
   logic [PC_W-1:0]     pc_d [HART_NUM];
   logic [HART_NUM-1:0] live_q, live_d;

   logic [PC_W-1:0]     if_pc_q, if_pc_d;
   logic [HID_W-1:0]    if_hart_id_q, if_hart_id_d;
   logic [HART_NUM-1:0] if_hstate_q, if_hstate_d;
   logic                if_valid_q, if_valid_d;

   logic [HART_NUM-1:0] ev_start, ev_kill, ev_br, ev_miss, ev_any;
   logic                issue_req, issue, stale;

   // Decode per-hart events; any of them makes that hart's in-flight or pending fetch stale.
   always_comb begin
      for (int h = 0; h < HART_NUM; h++) begin
         ev_start[h] = hstart   && (set_hart_id     == HID_W'(h));
         ev_kill[h]  = hkill    && (set_hart_id     == HID_W'(h));
         ev_br[h]    = br_taken && (br_hart_id      == HID_W'(h));
         ev_miss[h]  = ic_miss  && (ic_miss_hart_id == HID_W'(h));
         ev_any[h]   = ev_start[h] | ev_kill[h] | ev_br[h] | ev_miss[h];
      end
   end

   // Issue qualification: an event on the selected hart or a flush cancels this cycle's fetch.
   always_comb begin
      issue_req = (|hart_issue_hstate) & live_q[hart_issue_hid] & ~if_stall;
      issue     = issue_req & ~ev_any[hart_issue_hid] & ~if_flush;
      stale     = if_valid_q & ev_any[if_hart_id_q];
   end

   // Per-hart PC and live next state: start > kill > branch > miss > issue increment > hold.
   always_comb begin
      live_d = live_q;
      for (int h = 0; h < HART_NUM; h++) begin
         pc_d[h] = pc_q[h];
         if (ev_start[h]) begin
            pc_d[h]   = set_pc;
            live_d[h] = 1'b1;
         end else if (ev_kill[h]) begin
            live_d[h] = 1'b0;
         end else if (ev_br[h]) begin
            pc_d[h] = br_tgt;
         end else if (ev_miss[h]) begin
            pc_d[h] = ic_miss_pc;
         end else if (issue && (hart_issue_hid == HID_W'(h))) begin
            pc_d[h] = pc_q[h] + PC_W'(4);
         end
      end
   end

   // Output register next state: flush > issue > stale clear > stall hold > idle clear.
   always_comb begin
      if_pc_d      = if_pc_q;
      if_hart_id_d = if_hart_id_q;
      if_hstate_d  = if_hstate_q;
      if_valid_d   = if_valid_q;
      if (if_flush) begin
         if_hstate_d = '0;
         if_valid_d  = 1'b0;
      end else if (issue) begin
         if_pc_d      = pc_q[hart_issue_hid];
         if_hart_id_d = hart_issue_hid;
         if_hstate_d  = hart_issue_hstate;
         if_valid_d   = 1'b1;
      end else if (!if_stall || stale) begin
         if_hstate_d = '0;
         if_valid_d  = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int h = 0; h < HART_NUM; h++) begin
            pc_q[h] <= (h == 0) ? RESET_PC : '0;
         end
         live_q       <= HART_NUM'(1);
         if_pc_q      <= '0;
         if_hart_id_q <= '0;
         if_hstate_q  <= '0;
         if_valid_q   <= 1'b0;
      end else begin
         for (int h = 0; h < HART_NUM; h++) begin
            pc_q[h] <= pc_d[h];
         end
         live_q       <= live_d;
         if_pc_q      <= if_pc_d;
         if_hart_id_q <= if_hart_id_d;
         if_hstate_q  <= if_hstate_d;
         if_valid_q   <= if_valid_d;
      end
   end

   assign if_pc      = if_pc_q;
   assign if_hart_id = if_hart_id_q;
   assign if_hstate  = if_hstate_q;
   assign if_valid   = if_valid_q;
   assign hart_live  = live_q;

endmodule

// File: tb/tb_hart_fetch_pc.sv
// Self-checking bench for hart_fetch_pc: directed scenarios plus randomized traffic
// checked against a behavioural model of the per-hart PC file.
module tb_hart_fetch_pc;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  hart_issue_hid;
   logic [3:0]  hart_issue_hstate;
   logic        if_stall, if_flush, hstart, hkill, br_taken, ic_miss;
   logic [1:0]  set_hart_id, br_hart_id, ic_miss_hart_id;
   logic [31:0] set_pc, br_tgt, ic_miss_pc;
   logic [31:0] if_pc;
   logic [1:0]  if_hart_id;
   logic [3:0]  if_hstate;
   logic        if_valid;
   logic [3:0]  hart_live;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [31:0] m_pc [4];
   logic [3:0]  m_live;
   logic [31:0] m_if_pc;
   logic [1:0]  m_if_hid;
   logic [3:0]  m_if_hstate;
   logic        m_if_valid;

   hart_fetch_pc #(.HART_NUM(4), .PC_W(32), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .hart_issue_hid(hart_issue_hid), .hart_issue_hstate(hart_issue_hstate),
      .if_stall(if_stall), .if_flush(if_flush),
      .hstart(hstart), .hkill(hkill), .set_hart_id(set_hart_id), .set_pc(set_pc),
      .br_taken(br_taken), .br_hart_id(br_hart_id), .br_tgt(br_tgt),
      .ic_miss(ic_miss), .ic_miss_hart_id(ic_miss_hart_id), .ic_miss_pc(ic_miss_pc),
      .if_pc(if_pc), .if_hart_id(if_hart_id), .if_hstate(if_hstate),
      .if_valid(if_valid), .hart_live(hart_live)
   );

   always #5 clk = ~clk;

   task automatic idle();
      hart_issue_hid = 2'd0; hart_issue_hstate = 4'd0;
      if_stall = 0; if_flush = 0; hstart = 0; hkill = 0; br_taken = 0; ic_miss = 0;
      set_hart_id = 0; br_hart_id = 0; ic_miss_hart_id = 0;
      set_pc = 0; br_tgt = 0; ic_miss_pc = 0;
   endtask

   task automatic sel(input logic [1:0] h);
      hart_issue_hid = h;
      hart_issue_hstate = 4'b0001 << h;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic chk_fetch(input string name, input logic [1:0] h, input logic [31:0] pc);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== pc || if_hart_id !== h || if_hstate !== (4'b0001 << h)) begin
         errors++;
         $display("FAIL %s: got valid=%b pc=%h hid=%0d hstate=%b, want valid=1 pc=%h hid=%0d hstate=%b",
                  name, if_valid, if_pc, if_hart_id, if_hstate, pc, h, 4'b0001 << h);
      end
   endtask

   task automatic chk_idle(input string name);
      checks++;
      if (if_valid !== 1'b0 || if_hstate !== 4'b0000) begin
         errors++;
         $display("FAIL %s: got valid=%b hstate=%b, want valid=0 hstate=0000",
                  name, if_valid, if_hstate);
      end
   endtask

   task automatic test_reset();
      do_reset();
      sel(2'd0);
      tick();
      chk_fetch("pre_reset_fetch", 2'd0, RPC);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (if_valid !== 0 || if_pc !== 0 || if_hart_id !== 0 || if_hstate !== 0 || hart_live !== 4'b0001) begin
         errors++;
         $display("FAIL reset_state: got valid=%b pc=%h hid=%0d hstate=%b live=%b, want 0/0/0/0000/0001",
                  if_valid, if_pc, if_hart_id, if_hstate, hart_live);
      end
      @(negedge clk);
      rst = 1'b1;
      idle();
      #1;
   endtask

   task automatic test_issue_seq();
      do_reset();
      sel(2'd0);
      tick(); chk_fetch("seq0", 2'd0, 32'h100);
      tick(); chk_fetch("seq1", 2'd0, 32'h104);
      tick(); chk_fetch("seq2", 2'd0, 32'h108);
      idle();
      tick(); chk_idle("seq_idle");
   endtask

   task automatic test_hstart_alternate();
      do_reset();
      hstart = 1; set_hart_id = 2'd2; set_pc = 32'h2000;
      tick();
      idle();
      checks++;
      if (hart_live !== 4'b0101) begin
         errors++;
         $display("FAIL hstart_live: got %b want 0101", hart_live);
      end
      sel(2'd0); tick(); chk_fetch("alt0", 2'd0, 32'h100);
      sel(2'd2); tick(); chk_fetch("alt1", 2'd2, 32'h2000);
      sel(2'd0); tick(); chk_fetch("alt2", 2'd0, 32'h104);
      sel(2'd2); tick(); chk_fetch("alt3", 2'd2, 32'h2004);
      // Branch on h2 while h2 is both held and being issued.
      sel(2'd2); br_taken = 1; br_hart_id = 2'd2; br_tgt = 32'h3000;
      tick(); chk_idle("br_same_cycle");
      idle(); sel(2'd2);
      tick(); chk_fetch("br_retry", 2'd2, 32'h3000);
      idle();
   endtask

   task automatic test_multi_event();
      do_reset();
      hstart = 1; set_hart_id = 2'd1; set_pc = 32'h400;
      tick(); idle();
      sel(2'd0); tick(); chk_fetch("me_pre0", 2'd0, 32'h100);
      sel(2'd0); tick(); chk_fetch("me_pre1", 2'd0, 32'h104);
      idle();
      ic_miss = 1; ic_miss_hart_id = 2'd0; ic_miss_pc = 32'h104;
      br_taken = 1; br_hart_id = 2'd1; br_tgt = 32'h500;
      // h0 is held valid, so the miss makes it stale.
      tick(); chk_idle("me_stale");
      idle();
      sel(2'd0); tick(); chk_fetch("me_miss_pc0", 2'd0, 32'h104);
      sel(2'd1); tick(); chk_fetch("me_br_pc1", 2'd1, 32'h500);
      idle();
   endtask

   task automatic test_kill();
      do_reset();
      hstart = 1; set_hart_id = 2'd2; set_pc = 32'h2000;
      tick(); idle();
      hkill = 1; set_hart_id = 2'd2;
      tick(); idle();
      checks++;
      if (hart_live !== 4'b0001) begin
         errors++;
         $display("FAIL kill_live: got %b want 0001", hart_live);
      end
      sel(2'd2); tick(); chk_idle("kill_no_fetch");
      idle();
      hstart = 1; hkill = 1; set_hart_id = 2'd3; set_pc = 32'h700;
      tick(); idle();
      checks++;
      if (hart_live !== 4'b1001) begin
         errors++;
         $display("FAIL start_kill_live: got %b want 1001", hart_live);
      end
      sel(2'd3); tick(); chk_fetch("start_wins_fetch", 2'd3, 32'h700);
      idle();
   endtask

   task automatic test_stall_flush();
      do_reset();
      sel(2'd0); tick(); chk_fetch("st_first", 2'd0, 32'h100);
      if_stall = 1;
      tick(); chk_fetch("st_hold0", 2'd0, 32'h100);
      tick(); chk_fetch("st_hold1", 2'd0, 32'h100);
      if_stall = 0;
      tick(); chk_fetch("st_resume", 2'd0, 32'h104);
      // Flush overrides stall hold.
      idle(); if_stall = 1; if_flush = 1;
      tick(); chk_idle("flush_over_stall");
      idle(); sel(2'd0); tick(); chk_fetch("st_refetch", 2'd0, 32'h108);
      // Branch on the held hart during stall makes it stale.
      idle(); if_stall = 1; br_taken = 1; br_hart_id = 2'd0; br_tgt = 32'h900;
      tick(); chk_idle("stall_stale");
      idle(); sel(2'd0); tick(); chk_fetch("stale_refetch", 2'd0, 32'h900);
      idle();
   endtask

   task automatic test_wrap();
      do_reset();
      hstart = 1; set_hart_id = 2'd1; set_pc = 32'hFFFF_FFFC;
      tick(); idle();
      sel(2'd1); tick(); chk_fetch("wrap_top", 2'd1, 32'hFFFF_FFFC);
      sel(2'd1); tick(); chk_fetch("wrap_zero", 2'd1, 32'h0);
      idle();
   endtask

   // Behavioural model: output decided from pre-edge state, then PC writes applied
   // from lowest to highest priority so the strongest event lands last.
   task automatic model_step();
      logic [3:0] ev;
      logic       iss, stale;
      for (int h = 0; h < 4; h++) begin
         ev[h] = ((hstart || hkill) && set_hart_id == h) || (br_taken && br_hart_id == h) ||
                 (ic_miss && ic_miss_hart_id == h);
      end
      iss = (hart_issue_hstate != 0) && m_live[hart_issue_hid] && !if_stall && !if_flush &&
            !ev[hart_issue_hid];
      stale = m_if_valid && ev[m_if_hid];
      if (if_flush) begin
         m_if_valid = 0; m_if_hstate = 0;
      end else if (iss) begin
         m_if_pc = m_pc[hart_issue_hid]; m_if_hid = hart_issue_hid;
         m_if_hstate = hart_issue_hstate; m_if_valid = 1;
      end else if (!if_stall || stale) begin
         m_if_valid = 0; m_if_hstate = 0;
      end
      if (iss) m_pc[hart_issue_hid] = m_pc[hart_issue_hid] + 32'd4;
      if (ic_miss) m_pc[ic_miss_hart_id] = ic_miss_pc;
      if (br_taken) m_pc[br_hart_id] = br_tgt;
      if (hkill) m_live[set_hart_id] = 1'b0;
      if (hstart) begin
         m_pc[set_hart_id] = set_pc;
         m_live[set_hart_id] = 1'b1;
      end
   endtask

   task automatic test_random();
      do_reset();
      m_pc[0] = RPC; m_pc[1] = 0; m_pc[2] = 0; m_pc[3] = 0;
      m_live = 4'b0001; m_if_pc = 0; m_if_hid = 0; m_if_hstate = 0; m_if_valid = 0;
      for (int n = 0; n < 400; n++) begin
         idle();
         hart_issue_hid = 2'($urandom_range(0, 3));
         hart_issue_hstate = ($urandom_range(0, 9) < 8) ? (4'b0001 << hart_issue_hid) : 4'b0000;
         if_stall = ($urandom_range(0, 99) < 15);
         if_flush = ($urandom_range(0, 99) < 5);
         hstart = ($urandom_range(0, 99) < 10);
         hkill = ($urandom_range(0, 99) < 5);
         set_hart_id = 2'($urandom_range(0, 3));
         set_pc = {$urandom} & 32'hFFFF_FFFC;
         br_taken = ($urandom_range(0, 99) < 10);
         br_hart_id = 2'($urandom_range(0, 3));
         br_tgt = {$urandom} & 32'hFFFF_FFFC;
         ic_miss = ($urandom_range(0, 99) < 10);
         ic_miss_hart_id = 2'($urandom_range(0, 3));
         ic_miss_pc = {$urandom} & 32'hFFFF_FFFC;
         model_step();
         tick();
         checks++;
         if (if_valid !== m_if_valid || if_hstate !== m_if_hstate || hart_live !== m_live ||
             (m_if_valid && (if_pc !== m_if_pc || if_hart_id !== m_if_hid))) begin
            errors++;
            $display("FAIL rand[%0d]: got v=%b pc=%h hid=%0d hs=%b live=%b, want v=%b pc=%h hid=%0d hs=%b live=%b",
                     n, if_valid, if_pc, if_hart_id, if_hstate, hart_live,
                     m_if_valid, m_if_pc, m_if_hid, m_if_hstate, m_live);
         end
      end
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_issue_seq();
      test_hstart_alternate();
      test_multi_event();
      test_kill();
      test_stall_flush();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
